// File: rtl/uart_telemetry_framer.sv
// Periodic ADC telemetry framer with UART echo path between frames.
// Optional checksum byte is enabled by defining TELEM_CHECKSUM_EN.
module uart_telemetry_framer #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 12,
    parameter int PERIOD_CYC = 100_000_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [7:0]               tx_data,
    output logic                     tx_data_valid,
    input  logic                     tx_data_ready,
    input  logic [7:0]               rx_data,
    input  logic                     rx_data_valid,
    output logic                     rx_data_ready,
    output logic                     frame_busy,
    output logic                     rx_drop
);

`ifdef TELEM_CHECKSUM_EN
    localparam int FRAME_LEN = 5 + 2 * NUM_CH;
`else
    localparam int FRAME_LEN = 4 + 2 * NUM_CH;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int CNT_W = $clog2(PERIOD_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [7:0]               seq;
    logic [CNT_W-1:0]         cnt;
    logic [NUM_CH*DATA_W-1:0] shadow;
    logic [15:0]              samp [NUM_CH];
    logic [7:0]               cur_byte;
    logic                     expired;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_samp
        assign samp[g] = 16'(shadow[g*DATA_W +: DATA_W]);
    end

    assign expired       = (cnt >= CNT_LAST);
    assign rx_data_ready = (state == ST_WAIT) && !tx_data_valid;

`ifdef TELEM_CHECKSUM_EN
    logic [7:0] chk;

    always_comb begin
        chk = seq + 8'(NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            chk = chk + samp[c][15:8] + samp[c][7:0];
        end
    end
`endif

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cur_byte = 8'h00;
        if (idx == IDX_W'(0))      cur_byte = 8'hA5;
        else if (idx == IDX_W'(1)) cur_byte = 8'h5A;
        else if (idx == IDX_W'(2)) cur_byte = seq;
        else if (idx == IDX_W'(3)) cur_byte = 8'(NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx == IDX_W'(4 + 2 * c)) cur_byte = samp[c][15:8];
            if (idx == IDX_W'(5 + 2 * c)) cur_byte = samp[c][7:0];
        end
`ifdef TELEM_CHECKSUM_EN
        if (idx == LAST_IDX) cur_byte = chk;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            seq           <= 8'h00;
            cnt           <= '0;
            shadow        <= '0;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            frame_busy    <= 1'b0;
            rx_drop       <= 1'b0;
        end else begin
            rx_drop <= rx_data_valid && !rx_data_ready;
            if (!expired) cnt <= cnt + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    state  <= ST_SEND;
                    cnt    <= '0;
                    shadow <= ch_data;
                end
                ST_SEND: begin
                    // Present a byte only after a one-cycle gap with valid low.
                    if (!tx_data_valid) begin
                        tx_data       <= cur_byte;
                        tx_data_valid <= 1'b1;
                        if (idx == IDX_W'(0)) frame_busy <= 1'b1;
                    end else if (tx_data_ready) begin
                        tx_data_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            idx        <= '0;
                            seq        <= seq + 8'd1;
                            frame_busy <= 1'b0;
                            state      <= ST_WAIT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // A pending echo byte defers the next frame; the counter keeps its value.
                    if (tx_data_valid) begin
                        if (tx_data_ready) tx_data_valid <= 1'b0;
                    end else if (rx_data_valid) begin
                        tx_data       <= rx_data;
                        tx_data_valid <= 1'b1;
                    end else if (expired) begin
                        state  <= ST_SEND;
                        cnt    <= '0;
                        shadow <= ch_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_telemetry_framer.sv
// Directed bench for uart_telemetry_framer: frame content, period, backpressure,
// echo/drop, snapshot, SEQ wrap and mid-frame reset. Honours TELEM_CHECKSUM_EN.
module tb_uart_telemetry_framer;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 12;
    localparam int PERIOD = 200;
`ifdef TELEM_CHECKSUM_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] ch_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        drop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q  [9];
    logic [7:0] frame0 [9];

    uart_telemetry_framer #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .PERIOD_CYC(PERIOD)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .ch_data      (ch_data),
        .tx_data      (tx_data),
        .tx_data_valid(tx_valid),
        .tx_data_ready(tx_ready),
        .rx_data      (rx_data),
        .rx_data_valid(rx_valid),
        .rx_data_ready(rx_ready),
        .frame_busy   (busy),
        .rx_drop      (drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] seq, input logic [11:0] c0,
                                            input logic [11:0] c1, input int i);
        logic [7:0] s;
        s = seq + 8'h02 + {4'h0, c0[11:8]} + c0[7:0] + {4'h0, c1[11:8]} + c1[7:0];
        case (i)
            0:       return 8'hA5;
            1:       return 8'h5A;
            2:       return seq;
            3:       return 8'h02;
            4:       return {4'h0, c0[11:8]};
            5:       return c0[7:0];
            6:       return {4'h0, c1[11:8]};
            7:       return c1[7:0];
            default: return s;
        endcase
    endfunction

    task automatic fill_exp(input logic [7:0] seq, input logic [11:0] c0, input logic [11:0] c1);
        for (int i = 0; i < 9; i++) exp_q[i] = exp_byte(seq, c0, c1, i);
    endtask

    // Waits (bounded) for a handshake cycle; returns the byte and the cycle it was seen.
    task automatic recv(output logic [7:0] b, output int t);
        b = 8'h00;
        t = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                b = tx_data;
                t = cyc;
                break;
            end
        end
        if (t < 0) check("recv_timeout", 32'd0, 32'd1);
    endtask

    task automatic rx_frame(input string tag, output int t0);
        logic [7:0] b;
        int t;
        t0 = -1;
        for (int i = 0; i < FLEN; i++) begin
            recv(b, t);
            if (i == 0) t0 = t;
            check($sformatf("%s_b%0d", tag, i), b, exp_q[i]);
        end
    endtask

    // Call on the negedge where reset is released.
    task automatic frame_after_reset(input string tag, output int t0);
        logic [7:0] b;
        int t;
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_idle_valid"}, tx_valid, 1'b0);
        @(negedge clk);
        check({tag, "_first_valid"}, tx_valid, 1'b1);
        check({tag, "_first_busy"}, busy, 1'b1);
        check({tag, "_b0"}, tx_data, exp_q[0]);
        t0 = cyc;
        for (int i = 1; i < FLEN; i++) begin
            recv(b, t);
            check($sformatf("%s_b%0d", tag, i), b, exp_q[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_rx_ready"}, rx_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_drop"}, drop, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        int t, t0, t1, t2, t3;

        rst_n    = 1'b0;
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        ch_data  = {12'hABC, 12'h123};
        frame0   = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEC};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Frame 0: exact bytes, first byte two cycles after release.
        for (int i = 0; i < 9; i++) exp_q[i] = frame0[i];
        frame_after_reset("f0", t0);
        repeat (3) @(negedge clk);
        check("f0_busy_after", busy, 1'b0);
        check("f0_idle_after", tx_valid, 1'b0);

        // Frame 1: spacing, 10-cycle backpressure on byte 4, drop during SEND.
        fill_exp(8'h01, 12'h123, 12'hABC);
        t1 = -1;
        for (int i = 0; i < 4; i++) begin
            recv(b, t);
            if (i == 0) t1 = t;
            check($sformatf("f1_b%0d", i), b, exp_q[i]);
        end
        check("f1_spacing", t1 - t0, PERIOD);
        @(negedge clk);
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("f1_hold_data", tx_data, exp_q[4]);
            check("f1_hold_valid", tx_valid, 1'b1);
            if (k == 4) begin
                check("f1_drop_pulse", drop, 1'b1);
                rx_valid = 1'b0;
            end
            if (k == 5) check("f1_drop_end", drop, 1'b0);
            if (k == 3) begin
                rx_valid = 1'b1;
                rx_data  = 8'h66;
            end
        end
        tx_ready = 1'b1;
        for (int i = 5; i < FLEN; i++) begin
            recv(b, t);
            check($sformatf("f1_b%0d", i), b, exp_q[i]);
        end

        // Echo in WAIT.
        repeat (5) @(negedge clk);
        check("echo_rx_ready", rx_ready, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        check("echo_valid", tx_valid, 1'b1);
        check("echo_data", tx_data, 8'h55);
        check("echo_rx_ready_low", rx_ready, 1'b0);
        check("echo_no_drop", drop, 1'b0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("echo_once", tx_valid, 1'b0);

        // Frame 2: ch0 changes mid-frame; snapshot must hold.
        fill_exp(8'h02, 12'h123, 12'hABC);
        t2 = -1;
        for (int i = 0; i < FLEN; i++) begin
            recv(b, t);
            if (i == 0) t2 = t;
            check($sformatf("f2_b%0d", i), b, exp_q[i]);
            if (i == 1) ch_data = {12'hABC, 12'hFFF};
        end
        check("f2_spacing", t2 - t1, PERIOD);

        fill_exp(8'h03, 12'hFFF, 12'hABC);
        rx_frame("f3", t3);
        check("f3_spacing", t3 - t2, PERIOD);

        // Run through to frame 256, whose SEQ wraps to 0x00.
        for (int f = 4; f < 256; f++) begin
            for (int i = 0; i < FLEN; i++) recv(b, t);
        end
        fill_exp(8'h00, 12'hFFF, 12'hABC);
        rx_frame("f256", t);
        check("wrap_spacing", t - t3, 253 * PERIOD);

        // Reset in the middle of frame 257 while byte 4 is presented.
        for (int i = 0; i < 4; i++) recv(b, t);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_valid", tx_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        fill_exp(8'h00, 12'hFFF, 12'hABC);
        frame_after_reset("post_rst", t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_telemetry_framer.md
# uart_telemetry_framer

Periodic UART telemetry framer sitting between the ADC voltage outputs and the `uart_tx` byte interface on the 100 MHz `sys_clk` domain. Every `PERIOD_CYC` cycles it snapshots `NUM_CH` ADC channels and emits one framed packet through a valid/ready byte handshake. Between frames it echoes bytes received from `uart_rx` back to the host, with proper backpressure and drop reporting.

## Interface
Parameters:
- `NUM_CH`, 2, number of channels, 1..32.
- `DATA_W`, 12, bits per channel sample, 1..16.
- `PERIOD_CYC`, 100_000_000, cycles from one frame start to the next (1 s at 100 MHz); must be ≥ 2 × frame length.

Ports:
- `sys_clk`  in  1  system clock (100 MHz).
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `ch_data`  in  NUM_CH*DATA_W  packed samples; ch0 in the LSBs.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_data_valid`  out  1  `tx_data` is valid.
- `tx_data_ready`  in  1  `uart_tx` accepts the byte.
- `rx_data`  in  8  byte from `uart_rx`.
- `rx_data_valid`  in  1  `rx_data` is valid.
- `rx_data_ready`  out  1  framer can take an echo byte.
- `frame_busy`  out  1  high while in SEND.
- `rx_drop`  out  1  one-cycle pulse when an rx byte is offered while `rx_data_ready`=0.

## Operation
- Frame byte order:
  - 0xA5, 0x5A, SEQ, NUM_CH.
  - Then per channel, ch0 first: HI, LO.
  - Then CHK, only when the macro is defined; see Configuration.
- Each sample is zero-extended to 16 bits; HI = [15:8], LO = [7:0].
- SEQ is an 8-bit counter. It increments after each complete frame and wraps 0xFF→0x00.
- CHK = 8-bit sum, modulo 256, of SEQ through the last LO byte. The header is excluded.
- States:
  - IDLE: entered on reset. Goes to SEND on the next cycle.
  - SEND: frame bytes are presented in order. After the last byte is accepted, goes to WAIT.
  - WAIT: echo service and period count. Goes to SEND when the period expires and no echo byte is pending.
- Snapshot: `ch_data` is registered into a shadow register on every transition into SEND. Input changes during a frame do not affect it.
- Period counter:
  - Clears on entry to SEND and increments every cycle.
  - Expiry is `cnt >= PERIOD_CYC-1`.
  - If an echo byte is outstanding at expiry, SEND begins the cycle after that byte is accepted; the counter is not reset by the delay.
- Echo:
  - `rx_data_ready` = (state==WAIT) && !`tx_data_valid`.
  - On `rx_data_valid`&&`rx_data_ready`: `tx_data`←`rx_data` and `tx_data_valid`←1 on the next edge.
- Drop: `rx_data_valid`&&!`rx_data_ready` pulses `rx_drop` for one cycle. The byte is discarded and SEND is not affected.
- Reset, asynchronous and usable at any point including mid-frame:
  - `tx_data`=0x00, `tx_data_valid`=0, `rx_data_ready`=0, `frame_busy`=0, `rx_drop`=0.
  - SEQ=0, byte index=0, period counter=0, state=IDLE.

## Timing
- A byte transfers on any cycle with `tx_data_valid`&&`tx_data_ready`.
- While `tx_data_valid`=1 and `tx_data_ready`=0, `tx_data` is held stable.
- In SEND, after each accepted byte:
  - `tx_data_valid` is 0 for exactly one cycle.
  - The next byte is presented with valid=1 on the cycle after that.
- First frame: first cycle after reset release is IDLE; `tx_data_valid`=1 with 0xA5 two cycles after reset release.
- `frame_busy` is registered: high from the cycle valid first rises with 0xA5 until the cycle after the last byte is accepted.
- Echo latency: an rx byte accepted at cycle t appears as `tx_data` with valid at t+1.
- Frame length: 4 + 2·NUM_CH (+1 with checksum).
- Frame start spacing: exactly `PERIOD_CYC` cycles when no echo is pending.

## Configuration
- `TELEM_CHECKSUM_EN` defined:
  - The CHK byte is appended and the frame has 5 + 2·NUM_CH bytes.
- Not defined:
  - No checksum logic is generated.
  - The frame ends after the last LO byte, 4 + 2·NUM_CH bytes.
  - All other behaviour is identical.

## Test plan
- NUM_CH=2, DATA_W=12, ch0=0x123, ch1=0xABC, ready tied 1, macro on -> bytes A5 5A 00 02 01 23 0A BC EC.
- Same inputs, PERIOD_CYC=200 -> second frame starts 200 cycles after the first, with SEQ=01 and CHK=ED. After 256 frames SEQ wraps to 00.
- Hold ready=0 for 10 cycles while byte 4 (0x01) is valid -> `tx_data` holds 0x01. The full frame is still exactly 9 bytes, with no loss or duplication.
- In WAIT, rx 0x55 -> next cycle `tx_data`=0x55 with valid=1. Rx 0x66 during SEND -> `rx_drop` pulses one cycle and 0x66 is never transmitted.
- Change `ch_data` to ch0=0xFFF during byte 2 -> the current frame still carries 01 23; the next frame carries 0F FF.
- Assert `sys_rst_n` low mid-frame -> all outputs go to their reset values immediately. After release the next frame starts at A5 with SEQ=00. With the macro off, the frame is 8 bytes with no CHK.
